// File: rtl/execute_memory_pipe_reg_if.sv
// EX/MEM boundary bundle: E-side capture fields and hazard controls in,
// registered M-side fields and debug counters out.
interface execute_memory_pipe_reg_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_WIDTH   = 5,
  parameter int RESULTSRC_WIDTH = 2,
  parameter int COUNT_WIDTH     = 16
);
  logic                       StallM;
  logic                       FlushM;
  logic                       ValidE;
  logic                       RegWriteE;
  logic                       MemWriteE;
  logic                       a_typeE;
  logic [RESULTSRC_WIDTH-1:0] ResultSrcE;
  logic [ADDRESS_WIDTH-1:0]   RdE;
  logic [DATA_WIDTH-1:0]      ALUResultE;
  logic [DATA_WIDTH-1:0]      WriteDataE;
  logic [DATA_WIDTH-1:0]      PCPlus4E;

  logic                       ValidM;
  logic                       RegWriteM;
  logic                       MemWriteM;
  logic                       a_typeM;
  logic [RESULTSRC_WIDTH-1:0] ResultSrcM;
  logic [ADDRESS_WIDTH-1:0]   RdM;
  logic [DATA_WIDTH-1:0]      ALUResultM;
  logic [DATA_WIDTH-1:0]      WriteDataM;
  logic [DATA_WIDTH-1:0]      PCPlus4M;
  logic [COUNT_WIDTH-1:0]     StallCount;
  logic [COUNT_WIDTH-1:0]     BubbleCount;

  modport master (
    output StallM, FlushM, ValidE, RegWriteE, MemWriteE, a_typeE,
           ResultSrcE, RdE, ALUResultE, WriteDataE, PCPlus4E,
    input  ValidM, RegWriteM, MemWriteM, a_typeM, ResultSrcM, RdM,
           ALUResultM, WriteDataM, PCPlus4M, StallCount, BubbleCount
  );

  modport slave (
    input  StallM, FlushM, ValidE, RegWriteE, MemWriteE, a_typeE,
           ResultSrcE, RdE, ALUResultE, WriteDataE, PCPlus4E,
    output ValidM, RegWriteM, MemWriteM, a_typeM, ResultSrcM, RdM,
           ALUResultM, WriteDataM, PCPlus4M, StallCount, BubbleCount
  );
endinterface

// File: rtl/execute_memory_pipe_reg.sv
// EX/MEM pipeline register with stall hold, flush/idle bubbles, x0-write
// suppression and saturating stall/bubble counters for hazard debug.
module execute_memory_pipe_reg #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_WIDTH   = 5,
  parameter int RESULTSRC_WIDTH = 2,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  execute_memory_pipe_reg_if.slave  bus
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  logic                       vld_p0;
  logic                       reg_write_p0;
  logic                       mem_write_p0;
  logic                       a_type_p0;
  logic [RESULTSRC_WIDTH-1:0] result_src_p0;
  logic [ADDRESS_WIDTH-1:0]   rd_p0;
  logic [DATA_WIDTH-1:0]      alu_result_p0;
  logic [DATA_WIDTH-1:0]      write_data_p0;
  logic [DATA_WIDTH-1:0]      pc_plus4_p0;
  logic [COUNT_WIDTH-1:0]     stall_cnt_p0;
  logic [COUNT_WIDTH-1:0]     bubble_cnt_p0;

  // E -> M boundary: priority is reset, flush, stall, idle bubble, capture
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p0        <= 1'b0;
      reg_write_p0  <= 1'b0;
      mem_write_p0  <= 1'b0;
      a_type_p0     <= 1'b0;
      result_src_p0 <= '0;
      rd_p0         <= '0;
      alu_result_p0 <= '0;
      write_data_p0 <= '0;
      pc_plus4_p0   <= '0;
      stall_cnt_p0  <= '0;
      bubble_cnt_p0 <= '0;
    end else if (bus.FlushM || (!bus.StallM && !bus.ValidE)) begin
      vld_p0        <= 1'b0;
      reg_write_p0  <= 1'b0;
      mem_write_p0  <= 1'b0;
      a_type_p0     <= 1'b0;
      result_src_p0 <= '0;
      rd_p0         <= '0;
      alu_result_p0 <= '0;
      write_data_p0 <= '0;
      pc_plus4_p0   <= '0;
      bubble_cnt_p0 <= sat_inc(bubble_cnt_p0);
    end else if (bus.StallM) begin
      stall_cnt_p0  <= sat_inc(stall_cnt_p0);
    end else begin
      vld_p0        <= 1'b1;
      reg_write_p0  <= bus.RegWriteE && (bus.RdE != '0);
      mem_write_p0  <= bus.MemWriteE;
      a_type_p0     <= bus.a_typeE;
      result_src_p0 <= bus.ResultSrcE;
      rd_p0         <= bus.RdE;
      alu_result_p0 <= bus.ALUResultE;
      write_data_p0 <= bus.WriteDataE;
      pc_plus4_p0   <= bus.PCPlus4E;
    end
  end

  assign bus.ValidM      = vld_p0;
  assign bus.RegWriteM   = reg_write_p0;
  assign bus.MemWriteM   = mem_write_p0;
  assign bus.a_typeM     = a_type_p0;
  assign bus.ResultSrcM  = result_src_p0;
  assign bus.RdM         = rd_p0;
  assign bus.ALUResultM  = alu_result_p0;
  assign bus.WriteDataM  = write_data_p0;
  assign bus.PCPlus4M    = pc_plus4_p0;
  assign bus.StallCount  = stall_cnt_p0;
  assign bus.BubbleCount = bubble_cnt_p0;

endmodule

// File: tb/tb_execute_memory_pipe_reg.sv
// Bench for the EX/MEM register: a 16-bit-counter and a 4-bit-counter instance
// share one stimulus stream and are compared against a reference model.
module tb_execute_memory_pipe_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        stall, flush, valid_e, rw_e, mw_e, at_e;
  logic [1:0]  rs_e;
  logic [4:0]  rd_e;
  logic [31:0] alu_e, wd_e, pc_e;

  int n_run  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  execute_memory_pipe_reg_if #(.COUNT_WIDTH(16)) bus16();
  execute_memory_pipe_reg_if #(.COUNT_WIDTH(4))  bus4();

  assign bus16.StallM = stall;    assign bus4.StallM = stall;
  assign bus16.FlushM = flush;    assign bus4.FlushM = flush;
  assign bus16.ValidE = valid_e;  assign bus4.ValidE = valid_e;
  assign bus16.RegWriteE = rw_e;  assign bus4.RegWriteE = rw_e;
  assign bus16.MemWriteE = mw_e;  assign bus4.MemWriteE = mw_e;
  assign bus16.a_typeE = at_e;    assign bus4.a_typeE = at_e;
  assign bus16.ResultSrcE = rs_e; assign bus4.ResultSrcE = rs_e;
  assign bus16.RdE = rd_e;        assign bus4.RdE = rd_e;
  assign bus16.ALUResultE = alu_e; assign bus4.ALUResultE = alu_e;
  assign bus16.WriteDataE = wd_e;  assign bus4.WriteDataE = wd_e;
  assign bus16.PCPlus4E = pc_e;    assign bus4.PCPlus4E = pc_e;

  execute_memory_pipe_reg #(.COUNT_WIDTH(16)) dut16 (.CLK(clk), .RST(rst), .bus(bus16.slave));
  execute_memory_pipe_reg #(.COUNT_WIDTH(4))  dut4  (.CLK(clk), .RST(rst), .bus(bus4.slave));

  // Reference model: the M-stage contents as a struct, counters as plain ints.
  typedef struct {
    bit          valid, rw, mw, at;
    bit [1:0]    rs;
    bit [4:0]    rd;
    bit [31:0]   alu, wd, pc;
  } mstage_t;

  mstage_t m;
  int st16, bu16, st4, bu4;

  function automatic mstage_t bubble();
    mstage_t b;
    b.valid = 0; b.rw = 0; b.mw = 0; b.at = 0;
    b.rs = 0; b.rd = 0; b.alu = 0; b.wd = 0; b.pc = 0;
    return b;
  endfunction

  function automatic int bump(int c, int maxv);
    return (c < maxv) ? c + 1 : maxv;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m = bubble();
      st16 = 0; bu16 = 0; st4 = 0; bu4 = 0;
    end else if (flush) begin
      m = bubble();
      bu16 = bump(bu16, 65535); bu4 = bump(bu4, 15);
    end else if (stall) begin
      st16 = bump(st16, 65535); st4 = bump(st4, 15);
    end else if (!valid_e) begin
      m = bubble();
      bu16 = bump(bu16, 65535); bu4 = bump(bu4, 15);
    end else begin
      m.valid = 1; m.rw = rw_e && (rd_e != 0); m.mw = mw_e; m.at = at_e;
      m.rs = rs_e; m.rd = rd_e; m.alu = alu_e; m.wd = wd_e; m.pc = pc_e;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ValidM",      32'(bus16.ValidM),      32'(m.valid));
      chk("RegWriteM",   32'(bus16.RegWriteM),   32'(m.rw));
      chk("MemWriteM",   32'(bus16.MemWriteM),   32'(m.mw));
      chk("a_typeM",     32'(bus16.a_typeM),     32'(m.at));
      chk("ResultSrcM",  32'(bus16.ResultSrcM),  32'(m.rs));
      chk("RdM",         32'(bus16.RdM),         32'(m.rd));
      chk("ALUResultM",  bus16.ALUResultM,       m.alu);
      chk("WriteDataM",  bus16.WriteDataM,       m.wd);
      chk("PCPlus4M",    bus16.PCPlus4M,         m.pc);
      chk("StallCount16",  32'(bus16.StallCount),  32'(st16));
      chk("BubbleCount16", 32'(bus16.BubbleCount), 32'(bu16));
      chk("StallCount4",   32'(bus4.StallCount),   32'(st4));
      chk("BubbleCount4",  32'(bus4.BubbleCount),  32'(bu4));
      chk("ValidM4",     32'(bus4.ValidM),       32'(m.valid));
      chk("ALUResultM4", bus4.ALUResultM,        m.alu);
      chk("ctrl_implies_valid",
          32'((bus16.RegWriteM || bus16.MemWriteM) && !bus16.ValidM), 32'd0);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; valid_e = 0; rw_e = 0; mw_e = 0; at_e = 0;
    rs_e = 0; rd_e = 0; alu_e = 0; wd_e = 0; pc_e = 0;
  endtask

  task automatic rand_inputs();
    valid_e = 1'($urandom); rw_e = 1'($urandom); mw_e = 1'($urandom); at_e = 1'($urandom);
    rs_e = 2'($urandom); rd_e = 5'($urandom); alu_e = $urandom; wd_e = $urandom; pc_e = $urandom;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    rand_inputs();
    tick();
    chk_en = 1;
    rand_inputs();
    tick();
    chk("rst_ValidM",      32'(bus16.ValidM), 32'd0);
    chk("rst_ALUResultM",  bus16.ALUResultM, 32'd0);
    chk("rst_StallCount",  32'(bus16.StallCount), 32'd0);
    chk("rst_BubbleCount", 32'(bus16.BubbleCount), 32'd0);

    // Capture
    rst = 0; idle_inputs();
    valid_e = 1; rw_e = 1; rd_e = 5; alu_e = 32'h0000_1234; pc_e = 32'h0000_0010;
    rs_e = 2'b01; wd_e = 32'hA5A5_0001; at_e = 1;
    tick();
    chk("cap_RdM",        32'(bus16.RdM), 32'd5);
    chk("cap_RegWriteM",  32'(bus16.RegWriteM), 32'd1);
    chk("cap_ALUResultM", bus16.ALUResultM, 32'h1234);
    chk("cap_PCPlus4M",   bus16.PCPlus4M, 32'h10);
    chk("cap_ResultSrcM", 32'(bus16.ResultSrcM), 32'd1);
    chk("cap_ValidM",     32'(bus16.ValidM), 32'd1);

    // Stall three cycles while E moves on
    stall = 1; alu_e = 32'hDEAD_BEEF;
    tick(3);
    chk("stall_ALUResultM", bus16.ALUResultM, 32'h1234);
    chk("stall_StallCount", 32'(bus16.StallCount), 32'd3);
    stall = 0;
    tick();
    chk("release_ALUResultM", bus16.ALUResultM, 32'hDEAD_BEEF);

    // Flush wins over stall
    stall = 1; flush = 1; mw_e = 1;
    tick();
    chk("flush_ValidM",      32'(bus16.ValidM), 32'd0);
    chk("flush_MemWriteM",   32'(bus16.MemWriteM), 32'd0);
    chk("flush_RegWriteM",   32'(bus16.RegWriteM), 32'd0);
    chk("flush_RdM",         32'(bus16.RdM), 32'd0);
    chk("flush_BubbleCount", 32'(bus16.BubbleCount), 32'd1);
    chk("flush_StallCount",  32'(bus16.StallCount), 32'd3);

    // Write to x0 is dropped, rest captured
    stall = 0; flush = 0; mw_e = 0;
    valid_e = 1; rw_e = 1; rd_e = 0; alu_e = 32'h55;
    tick();
    chk("x0_RegWriteM",  32'(bus16.RegWriteM), 32'd0);
    chk("x0_ALUResultM", bus16.ALUResultM, 32'h55);
    chk("x0_ValidM",     32'(bus16.ValidM), 32'd1);

    // Idle E inserts a bubble
    valid_e = 0; rw_e = 1; rd_e = 7;
    tick();
    chk("idle_ValidM",      32'(bus16.ValidM), 32'd0);
    chk("idle_BubbleCount", 32'(bus16.BubbleCount), 32'd2);

    // Stall over a bubble keeps it a bubble, then drive counters into saturation
    stall = 1; valid_e = 1;
    tick();
    chk("stallbub_ValidM",     32'(bus16.ValidM), 32'd0);
    chk("stallbub_RegWriteM",  32'(bus16.RegWriteM), 32'd0);
    chk("stallbub_StallCount", 32'(bus16.StallCount), 32'd4);
    tick(20);
    chk("sat_StallCount4",  32'(bus4.StallCount), 32'd15);
    chk("sat_StallCount16", 32'(bus16.StallCount), 32'd24);

    // Reset wins over flush and stall, then normal priority resumes
    rst = 1; flush = 1;
    tick();
    chk("rstmid_StallCount4",  32'(bus4.StallCount), 32'd0);
    chk("rstmid_BubbleCount4", 32'(bus4.BubbleCount), 32'd0);
    rst = 0; flush = 0;
    tick();
    chk("resume_StallCount4", 32'(bus4.StallCount), 32'd1);
    chk("resume_ValidM",      32'(bus16.ValidM), 32'd0);

    // Mixed traffic checked by the model alone
    for (int i = 0; i < 60; i++) begin
      rand_inputs();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 5) == 0);
      rst   = ($urandom_range(0, 29) == 0);
      tick();
    end
    rst = 0; idle_inputs();
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_memory_pipe_reg.md
Name: execute_memory_pipe_reg

Overview:
Parametrised EX/MEM pipeline register for the RV32I pipelined core. It sits between the Execute and Memory stages and captures ALU result, store data, PC+4, destination register and control bits. On top of plain capture, it adds a synchronous reset, stall (hold), flush (bubble insertion), a valid bit, x0-write suppression, and saturating stall/bubble counters for hazard-unit debug.

Parameters:
DATA_WIDTH, 32, width of ALUResult/WriteData/PCPlus4 datapath fields
ADDRESS_WIDTH, 5, register-file address width of Rd
RESULTSRC_WIDTH, 2, width of ResultSrc select field
COUNT_WIDTH, 16, width of each saturating event counter

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous active-high reset
StallM  input  1  hold all M-side registers this cycle
FlushM  input  1  load a bubble this cycle
ValidE  input  1  E-stage holds a real instruction
RegWriteE  input  1  register write enable from E
MemWriteE  input  1  data memory write enable from E
a_typeE  input  1  access-type flag from E
ResultSrcE  input  RESULTSRC_WIDTH  writeback select from E
RdE  input  ADDRESS_WIDTH  destination register from E
ALUResultE  input  DATA_WIDTH  ALU result
WriteDataE  input  DATA_WIDTH  store data
PCPlus4E  input  DATA_WIDTH  PC+4
ValidM  output  1  M-stage holds a real instruction
RegWriteM  output  1  registered RegWrite (after suppression)
MemWriteM  output  1  registered MemWrite
a_typeM  output  1  registered a_type
ResultSrcM  output  RESULTSRC_WIDTH  registered ResultSrc
RdM  output  ADDRESS_WIDTH  registered Rd
ALUResultM  output  DATA_WIDTH  registered ALU result
WriteDataM  output  DATA_WIDTH  registered store data
PCPlus4M  output  DATA_WIDTH  registered PC+4
StallCount  output  COUNT_WIDTH  cycles with StallM applied (saturating)
BubbleCount  output  COUNT_WIDTH  bubbles loaded (saturating)

Behaviour:
- One-cycle latency: E inputs sampled at rising edge, visible on M outputs after that edge.
- Per-edge priority: RST > FlushM > StallM > ValidE=0 > normal capture.
- RST: every output, including both counters, goes to 0 (all fields zero; ValidM=0).
- FlushM=1 (regardless of StallM): bubble. ValidM, RegWriteM, MemWriteM and a_typeM go to 0. ResultSrcM, RdM, ALUResultM, WriteDataM and PCPlus4M go to 0. BubbleCount increments. StallCount is unchanged, even if StallM=1.
- StallM=1, FlushM=0: all M outputs hold their previous values. StallCount increments.
- ValidE=0, no stall/flush: same bubble load as flush, and BubbleCount increments.
- Normal capture: all fields copy their E inputs and ValidM=1.
- x0 suppression: on normal capture with RdE=0, RegWriteM=0. All other fields are captured as normal.
- Control bits are never asserted on a bubble. The invariant is: RegWriteM or MemWriteM implies ValidM.
- Counters saturate at all-ones (no wrap) and only clear on RST.
- A stall with no prior valid instruction holds the bubble; ValidM stays 0.
- Reset asserted mid-stall or mid-flush: reset wins on that edge. The next edge resumes normal priority.
- No combinational path from any input to any output.

Test Plan:
- Reset: drive RST=1 for 2 cycles with random E inputs -> all outputs 0, StallCount=0, BubbleCount=0.
- Capture: ValidE=1, RegWriteE=1, RdE=5, ALUResultE=0x0000_1234, PCPlus4E=0x0000_0010, ResultSrcE=2'b01 -> next cycle RdM=5, RegWriteM=1, ALUResultM=0x1234, PCPlus4M=0x10, ResultSrcM=01, ValidM=1.
- Stall: after the capture above, StallM=1 for 3 cycles while E changes to ALUResultE=0xDEAD_BEEF -> M outputs stay at 0x1234 and StallCount=3. Release StallM -> next cycle ALUResultM=0xDEADBEEF.
- Flush over stall: StallM=1 and FlushM=1 together with MemWriteE=1 -> next cycle ValidM=0, MemWriteM=0, RegWriteM=0, RdM=0, BubbleCount incremented by 1, StallCount unchanged.
- x0 suppression: ValidE=1, RegWriteE=1, RdE=0, ALUResultE=0x55 -> RegWriteM=0, ALUResultM=0x55, ValidM=1.
- Saturation: with COUNT_WIDTH=4, hold StallM=1 for 20 cycles -> StallCount reaches 15 and stays at 15. Reset mid-run -> 0 on the next edge.
